// File: rtl/br_predict_unit.sv
// Branch unit with BTB + 2-bit BHT prediction, execute-side resolve,
// training, registered redirect and performance counters.
module br_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_INIT    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] f_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_br_sig,
  input  logic [2:0]      ex_br_op,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc_plus4,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispred
);

  localparam int BHW = $clog2(BHT_ENTRIES);
  localparam int BTW = $clog2(BTB_ENTRIES);
  localparam int TW  = XLEN - BTW - 2;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd2;
  localparam logic [2:0] BR_BGE  = 3'd3;
  localparam logic [2:0] BR_BLTU = 3'd4;
  localparam logic [2:0] BR_BGEU = 3'd5;
  localparam logic [2:0] BR_JALR = 3'd6;
  localparam logic [2:0] BR_JAL  = 3'd7;

  typedef struct packed {
    logic            valid;
    logic [TW-1:0]   tag;
    logic [XLEN-1:0] target;
    logic            is_jump;
  } btb_t;

  btb_t       btb_q [BTB_ENTRIES];
  logic [1:0] bht_q [BHT_ENTRIES];

  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [31:0]     perf_br_q, perf_br_d;
  logic [31:0]     perf_mp_q, perf_mp_d;

  // Fetch-side prediction
  logic [BHW-1:0] f_bidx;
  logic [BTW-1:0] f_tidx;
  btb_t           f_ent;
  logic           f_hit;

  assign f_bidx = f_pc[BHW+1:2];
  assign f_tidx = f_pc[BTW+1:2];
  assign f_ent  = btb_q[f_tidx];
  assign f_hit  = f_ent.valid && (f_ent.tag == f_pc[XLEN-1:BTW+2]);

  assign pred_taken  = f_hit && (f_ent.is_jump || bht_q[f_bidx][1]);
  assign pred_target = pred_taken ? f_ent.target : f_pc + FOUR;

  // Execute-side resolve
  logic [BHW-1:0]  e_bidx;
  logic [BTW-1:0]  e_tidx;
  logic [TW-1:0]   e_tag;
  logic [XLEN-1:0] br_tgt;
  logic            is_cond, is_jmp, taken, mispred, alias_hit;
  logic [XLEN-1:0] target;
  logic [1:0]      cnt, cnt_d;

  assign pc_plus4 = ex_pc + FOUR;
  assign br_tgt   = ex_pc + ex_imm;
  assign e_bidx   = ex_pc[BHW+1:2];
  assign e_tidx   = ex_pc[BTW+1:2];
  assign e_tag    = ex_pc[XLEN-1:BTW+2];
  assign cnt      = bht_q[e_bidx];

  always_comb begin
    is_cond = 1'b0;
    is_jmp  = 1'b0;
    taken   = 1'b0;
    target  = pc_plus4;
    if (ex_br_sig) begin
      case (ex_br_op)
        BR_BEQ: begin
          is_cond = 1'b1;
          taken   = ex_rs1 == ex_rs2;
          target  = br_tgt;
        end
        BR_BNE: begin
          is_cond = 1'b1;
          taken   = ex_rs1 != ex_rs2;
          target  = br_tgt;
        end
        BR_BLT: begin
          is_cond = 1'b1;
          taken   = $signed(ex_rs1) < $signed(ex_rs2);
          target  = br_tgt;
        end
        BR_BGE: begin
          is_cond = 1'b1;
          taken   = $signed(ex_rs1) >= $signed(ex_rs2);
          target  = br_tgt;
        end
        BR_BLTU: begin
          is_cond = 1'b1;
          taken   = ex_rs1 < ex_rs2;
          target  = br_tgt;
        end
        BR_BGEU: begin
          is_cond = 1'b1;
          taken   = ex_rs1 >= ex_rs2;
          target  = br_tgt;
        end
        BR_JAL: begin
          is_jmp = 1'b1;
          taken  = 1'b1;
          target = ex_alu_out;
        end
        BR_JALR: begin
          is_jmp = 1'b1;
          taken  = 1'b1;
          target = {ex_alu_out[XLEN-1:1], 1'b0};
        end
        default: ;
      endcase
    end
  end

  assign mispred = ex_valid &&
    ((ex_pred_taken != taken) ||
     (taken && (ex_pred_target != target)));

  // A non-branch that was predicted taken aliased onto a stale BTB entry
  assign alias_hit = !ex_br_sig && ex_pred_taken &&
    btb_q[e_tidx].valid && (btb_q[e_tidx].tag == e_tag);

  always_comb begin
    cnt_d = cnt;
    if (taken) begin
      if (cnt != 2'd3) cnt_d = cnt + 2'd1;
    end else begin
      if (cnt != 2'd0) cnt_d = cnt - 2'd1;
    end
  end

  always_comb begin
    redirect_valid_d = mispred;
    redirect_pc_d    = redirect_pc_q;
    perf_br_d        = perf_br_q;
    perf_mp_d        = perf_mp_q;
    if (mispred) begin
      redirect_pc_d = taken ? target : pc_plus4;
      perf_mp_d     = perf_mp_q + 32'd1;
    end
    if (ex_valid && ex_br_sig) perf_br_d = perf_br_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i].valid <= 1'b0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'(CNT_INIT);
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      perf_br_q        <= '0;
      perf_mp_q        <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      perf_br_q        <= perf_br_d;
      perf_mp_q        <= perf_mp_d;
      if (ex_valid) begin
        if (is_cond) bht_q[e_bidx] <= cnt_d;
        if (taken) begin
          btb_q[e_tidx] <= '{valid: 1'b1, tag: e_tag,
                             target: target, is_jump: is_jmp};
        end else if (alias_hit) begin
          btb_q[e_tidx].valid <= 1'b0;
        end
      end
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign perf_branches  = perf_br_q;
  assign perf_mispred   = perf_mp_q;

endmodule

// File: tb/tb_br_predict_unit.sv
// Directed bench for br_predict_unit: redirect expectations go through
// a scoreboard queue, predictions and counters checked directly.
module tb_br_predict_unit;

  localparam logic [2:0] BEQ  = 3'd0;
  localparam logic [2:0] BNE  = 3'd1;
  localparam logic [2:0] BLT  = 3'd2;
  localparam logic [2:0] BGE  = 3'd3;
  localparam logic [2:0] BLTU = 3'd4;
  localparam logic [2:0] BGEU = 3'd5;
  localparam logic [2:0] JALR = 3'd6;
  localparam logic [2:0] JAL  = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_br_sig;
  logic [2:0]  ex_br_op;
  logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2, ex_alu_out;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] perf_branches, perf_mispred;

  typedef struct {
    logic        rv;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          failed = 0;
  logic [31:0] n_br = 0;
  logic [31:0] n_mp = 0;

  always #5 clk = ~clk;

  br_predict_unit dut (
    .clk(clk), .rst(rst), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_br_sig(ex_br_sig), .ex_br_op(ex_br_op),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_alu_out(ex_alu_out), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .pc_plus4(pc_plus4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .perf_branches(perf_branches), .perf_mispred(perf_mispred)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ex_set(input logic brsig, input logic [2:0] op,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] alu, input logic ptk,
                        input logic [31:0] ptgt, input logic erv,
                        input logic [31:0] epc);
    ex_valid = 1'b1;
    ex_br_sig = brsig;
    ex_br_op = op;
    ex_pc = pc;
    ex_imm = imm;
    ex_rs1 = rs1;
    ex_rs2 = rs2;
    ex_alu_out = alu;
    ex_pred_taken = ptk;
    ex_pred_target = ptgt;
    sb.push_back('{rv: erv, pc: epc});
    if (brsig) n_br++;
    if (erv) n_mp++;
  endtask

  task automatic ex_fin(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    e = sb.pop_front();
    chk({tag, "_rv"}, {31'd0, redirect_valid}, {31'd0, e.rv});
    if (e.rv) chk({tag, "_rpc"}, redirect_pc, e.pc);
  endtask

  task automatic ex_go(input string tag, input logic brsig,
                       input logic [2:0] op, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] alu,
                       input logic ptk, input logic [31:0] ptgt,
                       input logic erv, input logic [31:0] epc);
    ex_set(brsig, op, pc, imm, rs1, rs2, alu, ptk, ptgt, erv, epc);
    ex_fin(tag);
  endtask

  task automatic pred_chk(input string tag, input logic [31:0] pc,
                          input logic etk, input logic [31:0] etgt);
    f_pc = pc;
    #1;
    chk({tag, "_ptk"}, {31'd0, pred_taken}, {31'd0, etk});
    chk({tag, "_ptgt"}, pred_target, etgt);
  endtask

  initial begin
    rst = 1'b1;
    f_pc = 32'h100;
    ex_valid = 1'b0;
    ex_br_sig = 1'b0;
    ex_br_op = BEQ;
    ex_pc = 0;
    ex_imm = 0;
    ex_rs1 = 0;
    ex_rs2 = 0;
    ex_alu_out = 0;
    ex_pred_taken = 1'b0;
    ex_pred_target = 0;
    repeat (2) @(posedge clk);
    #1;
    pred_chk("rst", 32'h100, 1'b0, 32'h104);
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_pbr", perf_branches, 32'd0);
    chk("rst_pmp", perf_mispred, 32'd0);
    rst = 1'b0;

    // Cold BEQ taken; fetch in the same cycle still sees the old state
    ex_set(1, BEQ, 32'h100, 32'h40, 5, 5, 0, 0, 0, 1, 32'h140);
    pred_chk("same_cyc", 32'h100, 1'b0, 32'h104);
    chk("pc4", pc_plus4, 32'h104);
    ex_fin("beq_cold");
    pred_chk("beq_trained", 32'h100, 1'b1, 32'h140);

    // Compare flavours on boundary operands
    ex_go("bltu", 1, BLTU, 32'h204, 32'h10, 1, 32'hFFFF_FFFF, 0,
          0, 0, 1, 32'h214);
    ex_go("bgeu", 1, BGEU, 32'h308, 32'h10, 1, 32'hFFFF_FFFF, 0,
          0, 0, 0, 0);
    ex_go("blt", 1, BLT, 32'h30C, 32'h10, 1, 32'hFFFF_FFFF, 0,
          0, 0, 0, 0);
    ex_go("bne", 1, BNE, 32'h310, 32'h10, 3, 4, 0,
          1, 32'h320, 0, 0);
    ex_go("bge", 1, BGE, 32'h314, 32'h10, 32'hFFFF_FFFF, 1, 0,
          1, 32'h324, 1, 32'h318);
    pred_chk("btb_bltu", 32'h204, 1'b1, 32'h214);

    // Counter walks down and saturates at 0
    ex_go("nt1", 1, BEQ, 32'h100, 32'h40, 1, 2, 0,
          1, 32'h140, 1, 32'h104);
    pred_chk("cnt1", 32'h100, 1'b0, 32'h104);
    ex_go("nt2", 1, BEQ, 32'h100, 32'h40, 1, 2, 0, 0, 0, 0, 0);
    ex_go("nt3", 1, BEQ, 32'h100, 32'h40, 1, 2, 0, 0, 0, 0, 0);
    ex_go("tk1", 1, BEQ, 32'h100, 32'h40, 7, 7, 0,
          0, 0, 1, 32'h140);
    pred_chk("cnt_sat", 32'h100, 1'b0, 32'h104);
    ex_go("tk2", 1, BEQ, 32'h100, 32'h40, 7, 7, 0,
          0, 0, 1, 32'h140);
    pred_chk("cnt2", 32'h100, 1'b1, 32'h140);

    // Jumps
    ex_go("jalr_ok", 1, JALR, 32'h40C, 0, 0, 0, 32'h2001,
          1, 32'h2000, 0, 0);
    ex_go("jalr_bad", 1, JALR, 32'h40C, 0, 0, 0, 32'h2001,
          1, 32'h2004, 1, 32'h2000);
    pred_chk("jalr_btb", 32'h40C, 1'b1, 32'h2000);
    ex_go("jal", 1, JAL, 32'h410, 0, 0, 0, 32'h3000,
          0, 0, 1, 32'h3000);
    chk("perf_br", perf_branches, n_br);
    chk("perf_mp", perf_mispred, n_mp);

    // Non-branch aliasing onto a BTB entry
    ex_go("plain", 0, BEQ, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_go("alias", 0, BEQ, 32'h100, 0, 0, 0, 0,
          1, 32'h140, 1, 32'h104);
    pred_chk("alias_inv", 32'h100, 1'b0, 32'h104);
    chk("perf_br2", perf_branches, n_br);
    chk("perf_mp2", perf_mispred, n_mp);

    // Reset wins over a same-cycle mispredicting resolve
    ex_go("pend", 1, BEQ, 32'h500, 32'h8, 1, 1, 0, 0, 0, 1, 32'h508);
    rst = 1'b1;
    ex_set(0, BEQ, 32'h40C, 0, 0, 0, 0, 1, 32'h2000, 0, 0);
    ex_fin("rst_ovr");
    rst = 1'b0;
    n_br = 0;
    n_mp = 0;
    chk("rst2_rpc", redirect_pc, 32'd0);
    chk("rst2_pbr", perf_branches, n_br);
    chk("rst2_pmp", perf_mispred, n_mp);
    pred_chk("rst2_btb", 32'h40C, 1'b0, 32'h410);
    ex_go("bne_nt", 1, BNE, 32'h600, 32'h20, 9, 9, 0, 0, 0, 0, 0);
    chk("rst2_pbr1", perf_branches, n_br);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
